// File: rtl/flash_responder_if.sv
// Parallel NOR-flash style bus between an initiator (master) and flash_responder (slave).
interface flash_responder_if;
    logic [21:0] flash_address;
    wire  [7:0]  flash_data;
    logic        flash_nce;
    logic        flash_noe;
    logic        flash_nwe;
    logic        flash_nrst;
    logic        ready;

    modport master (
        output flash_address, flash_nce, flash_noe, flash_nwe, flash_nrst,
        input  ready,
        inout  flash_data
    );

    modport slave (
        input  flash_address, flash_nce, flash_noe, flash_nwe, flash_nrst,
        output ready,
        inout  flash_data
    );
endinterface

// File: rtl/flash_responder.sv
// Behavioural NOR-flash responder: AMD-style unlock/program/chip-erase command set over a
// small emulated byte array, with RY/BY# and DQ7/DQ6 status polling during embedded operations.
module flash_responder #(
    parameter int MEM_AW       = 8,
    parameter int PROG_CYCLES  = 16,
    parameter int ERASE_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             nrst,
    flash_responder_if.slave bus
);
    localparam int DEPTH  = 2 ** MEM_AW;
    localparam int MAXC   = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
    localparam int CW_CYC = $clog2(MAXC + 1);
    localparam int CNT_W  = (CW_CYC > MEM_AW) ? CW_CYC : MEM_AW + 1;

    typedef enum logic [3:0] {
        ST_READ       = 4'd0,
        ST_UNLK1      = 4'd1,
        ST_UNLK2      = 4'd2,
        ST_PROG_ARM   = 4'd3,
        ST_ERS_UNLK1  = 4'd4,
        ST_ERS_UNLK2  = 4'd5,
        ST_ERS_ARM    = 4'd6,
        ST_PROG_BUSY  = 4'd7,
        ST_ERASE_BUSY = 4'd8
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MEM_AW-1:0] pa_q, pa_d;
    logic [7:0]        pd_q, pd_d;
    logic              ready_q, ready_d;
    logic              tog_q, tog_d;
    logic [7:0]        rd_q, rd_d;
    logic              nwe_prev_q, nwe_prev_d;
    logic              noe_prev_q, noe_prev_d;

    // Cells hold the complement of each byte so zero-initialised storage reads as erased (0xFF).
    logic [7:0]        cell_q [DEPTH];
    logic              mem_we_s;
    logic [MEM_AW-1:0] mem_waddr_s;
    logic [7:0]        mem_wcell_s;

    logic              wr_stb_s;
    logic              is_aaa_s;
    logic              is_555_s;
    logic              busy_s;
    logic              oe_s;
    logic [MEM_AW-1:0] idx_s;
    logic [7:0]        wdata_s;
    logic              unused_addr_s;

    assign idx_s         = bus.flash_address[MEM_AW-1:0];
    assign wdata_s       = bus.flash_data;
    assign is_aaa_s      = (bus.flash_address[11:0] == 12'hAAA);
    assign is_555_s      = (bus.flash_address[11:0] == 12'h555);
    assign wr_stb_s      = bus.flash_nwe & ~nwe_prev_q & ~bus.flash_nce;
    assign busy_s        = (state_q == ST_PROG_BUSY) || (state_q == ST_ERASE_BUSY);
    assign oe_s          = nrst & ~bus.flash_nce & ~bus.flash_noe & bus.flash_nwe;
    assign bus.flash_data = oe_s ? rd_q : 8'hzz;
    assign bus.ready     = ready_q;
    assign unused_addr_s = ^bus.flash_address[21:12];

    // Command sequencer, busy countdown and the single array write port
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pa_d        = pa_q;
        pd_d        = pd_q;
        ready_d     = ready_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = pa_q;
        mem_wcell_s = cell_q[pa_q] | ~pd_q;
        if (!bus.flash_nrst) begin
            // Device reset pin wins over any strobe in the same cycle.
            state_d = ST_READ;
            cnt_d   = '0;
            ready_d = 1'b1;
        end else begin
            case (state_q)
                ST_READ: begin
                    if (wr_stb_s && is_aaa_s && (wdata_s == 8'hAA)) begin
                        state_d = ST_UNLK1;
                    end else begin
                        state_d = ST_READ;
                    end
                end
                ST_UNLK1: begin
                    if (wr_stb_s) begin
                        state_d = (is_555_s && (wdata_s == 8'h55)) ? ST_UNLK2 : ST_READ;
                    end else begin
                        state_d = ST_UNLK1;
                    end
                end
                ST_UNLK2: begin
                    if (wr_stb_s && is_aaa_s && (wdata_s == 8'hA0)) begin
                        state_d = ST_PROG_ARM;
                    end else if (wr_stb_s && is_aaa_s && (wdata_s == 8'h80)) begin
                        state_d = ST_ERS_UNLK1;
                    end else if (wr_stb_s) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_UNLK2;
                    end
                end
                ST_PROG_ARM: begin
                    if (wr_stb_s) begin
                        state_d = ST_PROG_BUSY;
                        pa_d    = idx_s;
                        pd_d    = wdata_s;
                        cnt_d   = CNT_W'(PROG_CYCLES - 1);
                        ready_d = 1'b0;
                    end else begin
                        state_d = ST_PROG_ARM;
                    end
                end
                ST_ERS_UNLK1: begin
                    if (wr_stb_s) begin
                        state_d = (is_aaa_s && (wdata_s == 8'hAA)) ? ST_ERS_UNLK2 : ST_READ;
                    end else begin
                        state_d = ST_ERS_UNLK1;
                    end
                end
                ST_ERS_UNLK2: begin
                    if (wr_stb_s) begin
                        state_d = (is_555_s && (wdata_s == 8'h55)) ? ST_ERS_ARM : ST_READ;
                    end else begin
                        state_d = ST_ERS_UNLK2;
                    end
                end
                ST_ERS_ARM: begin
                    if (wr_stb_s && is_aaa_s && (wdata_s == 8'h10)) begin
                        state_d = ST_ERASE_BUSY;
                        cnt_d   = CNT_W'(ERASE_CYCLES - 1);
                        ready_d = 1'b0;
                    end else if (wr_stb_s) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_ERS_ARM;
                    end
                end
                ST_PROG_BUSY: begin
                    if (cnt_q == '0) begin
                        mem_we_s = 1'b1;
                        state_d  = ST_READ;
                        ready_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_ERASE_BUSY: begin
                    // The last DEPTH counts sweep the array, reaching byte 0 on the completion cycle.
                    if (cnt_q < CNT_W'(DEPTH)) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = cnt_q[MEM_AW-1:0];
                        mem_wcell_s = 8'h00;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                    if (cnt_q == '0) begin
                        state_d = ST_READ;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end
            endcase
        end
    end

    // Read-path register: array byte when idle, DQ7/DQ6 status while an operation runs
    always_comb begin
        nwe_prev_d = bus.flash_nwe;
        noe_prev_d = bus.flash_noe;
        tog_d      = tog_q ^ (noe_prev_q & ~bus.flash_noe & ~bus.flash_nce);
        if (busy_s) begin
            rd_d = {((state_q == ST_PROG_BUSY) ? ~pd_q[7] : 1'b0), tog_d, 6'b000000};
        end else begin
            rd_d = ~cell_q[idx_s];
        end
    end

    // Control and bus-side state; the cell array is intentionally outside any reset
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_READ;
            cnt_q      <= '0;
            pa_q       <= '0;
            pd_q       <= 8'h00;
            ready_q    <= 1'b1;
            tog_q      <= 1'b0;
            rd_q       <= 8'h00;
            nwe_prev_q <= 1'b1;
            noe_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pa_q       <= pa_d;
            pd_q       <= pd_d;
            ready_q    <= ready_d;
            tog_q      <= tog_d;
            rd_q       <= rd_d;
            nwe_prev_q <= nwe_prev_d;
            noe_prev_q <= noe_prev_d;
        end
    end

    // Array write port
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            cell_q[mem_waddr_s] <= mem_wcell_s;
        end
    end
endmodule

// File: doc/flash_responder.md
FLASH_RESPONDER -- requirements
Module: flash_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 8, meaning byte-array address width (2^MEM_AW bytes emulated).
REQ-002 SHALL have parameter PROG_CYCLES, default 16, meaning clk cycles busy per byte program.
REQ-003 SHALL have parameter ERASE_CYCLES, default 1024, meaning clk cycles busy per chip erase.
REQ-004 SHALL have port clk  in  1  system clock; all logic on posedge.
REQ-005 SHALL have port nrst  in  1  one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port flash_address  in  22  byte address from the initiator.
REQ-007 SHALL have port flash_data  inout  8  bidirectional data bus.
REQ-008 SHALL have port flash_nce  in  1  chip enable, active-low.
REQ-009 SHALL have port flash_noe  in  1  output enable, active-low.
REQ-010 SHALL have port flash_nwe  in  1  write enable, active-low.
REQ-011 SHALL have port flash_nrst  in  1  device reset pin, active-low, synchronous to clk.
REQ-012 SHALL have port ready  out  1  RY/BY#: 1 = ready, 0 = embedded operation in progress.

Function
REQ-013 Bus write SHALL be captured on the first clk edge where flash_nwe is 1 and was 0 on the previous edge, with flash_nce 0; address and data sampled at that edge.
REQ-014 Command decode SHALL compare flash_address[11:0] only; array SHALL be indexed by flash_address[MEM_AW-1:0].
REQ-015 States: READ, UNLK1, UNLK2, PROG_ARM, ERS_UNLK1, ERS_UNLK2, ERS_ARM, PROG_BUSY, ERASE_BUSY.
REQ-016 READ: write 0xAA@0xAAA -> UNLK1; write 0xF0 any address -> READ; other writes ignored.
REQ-017 UNLK1: write 0x55@0x555 -> UNLK2; any other write -> READ.
REQ-018 UNLK2: 0xA0@0xAAA -> PROG_ARM; 0x80@0xAAA -> ERS_UNLK1; any other write -> READ.
REQ-019 ERS_UNLK1 requires 0xAA@0xAAA -> ERS_UNLK2; ERS_UNLK2 requires 0x55@0x555 -> ERS_ARM; ERS_ARM requires 0x10@0xAAA -> ERASE_BUSY; any mismatch -> READ.
REQ-020 PROG_ARM: next write latches address A and data D -> PROG_BUSY; busy counter loaded with PROG_CYCLES-1.
REQ-021 Program SHALL only clear bits: on PROG_BUSY completion mem[A] <= mem[A] & D, then -> READ.
REQ-022 ERASE_BUSY completion SHALL set every array byte to 0xFF, then -> READ; erase MAY be implemented as a sequential sweep inside ERASE_CYCLES provided ERASE_CYCLES >= 2^MEM_AW.
REQ-023 Busy counter SHALL decrement once per clk; completion occurs the cycle the counter is 0; ready SHALL be 0 throughout PROG_BUSY/ERASE_BUSY and 1 the cycle after completion.
REQ-024 Writes during PROG_BUSY/ERASE_BUSY SHALL be ignored (no state change, no array change).
REQ-025 flash_data SHALL be driven only when flash_nce=0, flash_noe=0, flash_nwe=1; otherwise high-Z.
REQ-026 Read data SHALL be registered: value reflects flash_address sampled on previous clk edge (1-cycle latency).
REQ-027 READ and all unlock/arm states SHALL return mem[address]; an intervening read SHALL NOT abort a command sequence.
REQ-028 Busy-state reads SHALL return status: bit7 = ~D[7] (program) or 0 (erase); bit6 toggles on each falling edge of flash_noe with flash_nce=0; other bits 0.
REQ-029 flash_nrst=0 SHALL force READ, clear busy counter, set ready=1 on next edge; aborted program SHALL NOT modify array; aborted erase leaves array partially erased.
REQ-030 Simultaneous write strobe and flash_nrst=0: reset wins, write discarded.

Reset
REQ-031 nrst=0 SHALL asynchronously set state=READ, ready=1, busy counter=0, toggle bit=0, read register=0x00, flash_data high-Z.
REQ-032 Array contents SHALL NOT be affected by nrst or flash_nrst; simulation power-up value is 0xFF for all bytes.

Verification
REQ-033 AA@AAA,55@555,A0@AAA,0x5A@0x03 -> ready low 16 cycles, then read 0x03 = 0x5A.
REQ-034 Program 0xF0 then 0x3C to 0x07 -> read 0x07 = 0x30 (bits only cleared).
REQ-035 Program 0x00@0x01, poll during busy -> bit7=1, bit6 alternates per read; after ready, read 0x00.
REQ-036 Six-cycle erase sequence -> ready low 1024 cycles, all 256 bytes read 0xFF.
REQ-037 AA@AAA then 0x12@0x555 -> READ; following A0@AAA + data write leaves array unchanged.
REQ-038 flash_nrst pulsed low mid-program -> ready=1 next cycle, target byte unchanged; nrst low mid-erase -> state READ asynchronously.
